// File: rtl/decoder_onehot_scan.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with active-low enable.
// DIRECT mode loads the index via valid/ready; SCAN mode steps through every position with a programmable dwell.
module decoder_onehot_scan #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_in,
    input  logic                  mode_in,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  sel_valid_in,
    output logic                  sel_ready_out,
    input  logic [DWELL_W-1:0]    dwell_in,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx_out,
    output logic                  wrap_out
);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [DWELL_W-1:0]   cnt;
    logic [DWELL_W-1:0]   next_cnt;
    logic [SEL_W-1:0]     next_idx;
    logic [2**SEL_W-1:0]  next_out;
    logic                 next_wrap;
    logic                 scan_step;

    always_comb begin
        sel_ready_out = (state == DIRECT);
    end

    always_comb begin
        next_state = IDLE;
        next_idx   = idx_out;
        next_cnt   = '0;
        next_wrap  = 1'b0;
        next_out   = '0;
        // >= rather than == so a shrinking dwell_in steps at the next edge instead of waiting for counter wrap
        scan_step  = (state == SCAN) && (cnt >= dwell_in);

        if (!rst_n_in) begin
            next_state = IDLE;
            next_idx   = '0;
        end else if (en_in) begin
            next_state = IDLE;
        end else begin
            next_state = mode_in ? SCAN : DIRECT;
            if (state == DIRECT && sel_valid_in) begin
                next_idx = sel_in;
            end else if (scan_step) begin
                next_idx  = idx_out + 1'b1;
                next_wrap = (idx_out == '1);
            end
            if (next_state == SCAN && state == SCAN && !scan_step) begin
                next_cnt = cnt + 1'b1;
            end
        end

        if (next_state != IDLE) begin
            next_out[next_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        state    <= next_state;
        idx_out  <= next_idx;
        cnt      <= next_cnt;
        wrap_out <= next_wrap;
        out      <= next_out;
    end

endmodule
